// File: rtl/ins_mem_resp_pkg.sv
// Shared definitions for the instruction-memory responder: fetch-state encoding,
// default bus widths shared with the control unit / PC, and the NOP word.
package ins_mem_resp_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Returned in place of a stored word when the fetch address is out of range.
   localparam logic [DATA_W_DEF-1:0] NOP_INS = '0;

endpackage

// File: rtl/ins_mem_array.sv
// DEPTH x DATA_W instruction store: one write port, one read port whose result is
// captured into a register when rd_en is high. Contents are never cleared by reset.
module ins_mem_array
   import ins_mem_resp_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_now,
   output logic              rd_err_now,
   output logic [DATA_W-1:0] cap_data,
   output logic              cap_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_ok;

   // Unsigned range check: addresses at or beyond DEPTH never alias onto low words.
   assign wr_ok      = ({1'b0, wr_addr} < DEPTH_L);
   assign rd_err_now = !({1'b0, rd_addr} < DEPTH_L);
   assign rd_now     = rd_err_now ? DATA_W'(NOP_INS) : mem[rd_addr[IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (wr_en && wr_ok) begin
         mem[wr_addr[IDX_W-1:0]] <= wr_data;
      end
   end

   // Capture samples the pre-write contents, so a same-edge load is not seen.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_data <= '0;
         cap_err  <= 1'b0;
      end else if (rd_en) begin
         cap_data <= rd_now;
         cap_err  <= rd_err_now;
      end
   end

endmodule

// File: rtl/ins_mem_resp.sv
// Instruction-memory responder: accepts a one-cycle fetch pulse, returns the word
// READ_LAT cycles later with a one-cycle en_out pulse; includes the program load port.
module ins_mem_resp
   import ins_mem_resp_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DEPTH    = 256,
   parameter int READ_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_in,
   input  logic [ADDR_W-1:0] addr,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] ins,
   output logic              en_out,
   output logic              busy,
   output logic              req_drop,
   output logic              addr_err,
   output logic [1:0]        state_dbg
);

   // Handshake: a fetch is accepted only when en_in is high on an edge while busy
   // is low; the answer is the single cycle in which en_out is high, with ins and
   // addr_err valid in that cycle. There is no backpressure on the response.

   localparam int CNT_W = $clog2(READ_LAT + 1);

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic [DATA_W-1:0] rd_now;
   logic              rd_err_now;
   logic [DATA_W-1:0] cap_data;
   logic              cap_err;

   assign busy      = (state != ST_IDLE);
   assign accept    = en_in && (state == ST_IDLE);
   assign state_dbg = state;

   ins_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (load_en),
      .wr_addr    (load_addr),
      .wr_data    (load_data),
      .rd_en      (accept),
      .rd_addr    (addr),
      .rd_now     (rd_now),
      .rd_err_now (rd_err_now),
      .cap_data   (cap_data),
      .cap_err    (cap_err)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         ins      <= '0;
         en_out   <= 1'b0;
         req_drop <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         en_out   <= 1'b0;
         req_drop <= en_in && (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (en_in) begin
                  cnt      <= CNT_W'(READ_LAT - 1);
                  addr_err <= 1'b0;
                  // With single-cycle latency the response is raised on the accepting edge.
                  if (READ_LAT == 1) begin
                     state    <= ST_RESP;
                     en_out   <= 1'b1;
                     ins      <= rd_now;
                     addr_err <= rd_err_now;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state    <= ST_RESP;
                  en_out   <= 1'b1;
                  ins      <= cap_data;
                  addr_err <= cap_err;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ins_mem_resp.sv
// Bench for ins_mem_resp: three configurations share one stimulus stream and are
// checked against a cycle-count reference model through per-instance expected queues.
module tb_ins_mem_resp;
   import ins_mem_resp_pkg::*;

   localparam int NI   = 3;
   localparam int MAXE = 8192;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_in = 1'b0;
   logic [7:0]  addr = '0;
   logic        load_en = 1'b0;
   logic [7:0]  load_addr = '0;
   logic [15:0] load_data = '0;

   logic [15:0] ins_w    [NI];
   logic        en_out_w [NI];
   logic        busy_w   [NI];
   logic        drop_w   [NI];
   logic        err_w    [NI];
   logic [1:0]  st_w     [NI];

   int edge_cnt = 0;
   int compares = 0;
   int fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   ins_mem_resp #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .READ_LAT(2)) u0 (
      .clk(clk), .rst(rst_n), .en_in(en_in), .addr(addr), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .ins(ins_w[0]), .en_out(en_out_w[0]),
      .busy(busy_w[0]), .req_drop(drop_w[0]), .addr_err(err_w[0]), .state_dbg(st_w[0]));

   ins_mem_resp #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .READ_LAT(1)) u1 (
      .clk(clk), .rst(rst_n), .en_in(en_in), .addr(addr), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .ins(ins_w[1]), .en_out(en_out_w[1]),
      .busy(busy_w[1]), .req_drop(drop_w[1]), .addr_err(err_w[1]), .state_dbg(st_w[1]));

   ins_mem_resp #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .READ_LAT(3)) u2 (
      .clk(clk), .rst(rst_n), .en_in(en_in), .addr(addr), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .ins(ins_w[2]), .en_out(en_out_w[2]),
      .busy(busy_w[2]), .req_drop(drop_w[2]), .addr_err(err_w[2]), .state_dbg(st_w[2]));

   function automatic int lat_of(int i);
      case (i)
         0: return 2;
         1: return 1;
         default: return 3;
      endcase
   endfunction

   function automatic int dep_of(int i);
      return (i == 2) ? 128 : 256;
   endfunction

   // ---------------- reference model state ----------------
   logic [15:0] mem_m     [NI][256];
   int          free_edge [NI];
   bit          exp_busy  [NI][MAXE];
   bit          exp_drop  [NI][MAXE];
   logic [15:0] last_ins  [NI];

   // Expected response entries: {edge of en_out sample, addr_err, ins}
   logic [48:0] exp_q0[$];
   logic [48:0] exp_q1[$];
   logic [48:0] exp_q2[$];

   function automatic void q_push(int i, logic [48:0] v);
      case (i)
         0: exp_q0.push_back(v);
         1: exp_q1.push_back(v);
         default: exp_q2.push_back(v);
      endcase
   endfunction

   function automatic int q_size(int i);
      case (i)
         0: return exp_q0.size();
         1: return exp_q1.size();
         default: return exp_q2.size();
      endcase
   endfunction

   function automatic logic [48:0] q_pop(int i);
      case (i)
         0: return exp_q0.pop_front();
         1: return exp_q1.pop_front();
         default: return exp_q2.pop_front();
      endcase
   endfunction

   function automatic int q_front_edge(int i);
      logic [48:0] v;
      case (i)
         0: v = exp_q0[0];
         1: v = exp_q1[0];
         default: v = exp_q2[0];
      endcase
      return int'(v[48:17]);
   endfunction

   function automatic void q_flush(int i);
      case (i)
         0: exp_q0.delete();
         1: exp_q1.delete();
         default: exp_q2.delete();
      endcase
   endfunction

   function automatic void chk(string name, int i, logic [31:0] act, logic [31:0] exp);
      compares++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s u%0d edge %0d: got %0h expected %0h", name, i, edge_cnt, act, exp);
      end
   endfunction

   // ---------------- driver ----------------
   // Called at a falling edge; inputs are sampled on the next rising edge t.
   task automatic drive_cycle(input logic en, input logic [7:0] a, input logic ld,
                              input logic [7:0] la, input logic [15:0] ld_d);
      int t;
      t = edge_cnt + 1;
      en_in = en; addr = a; load_en = ld; load_addr = la; load_data = ld_d;
      for (int i = 0; i < NI; i++) begin
         int lat;
         int dep;
         logic err;
         logic [15:0] w;
         lat = lat_of(i);
         dep = dep_of(i);
         if (en) begin
            if (t >= free_edge[i]) begin
               err = (int'(a) >= dep);
               w = err ? 16'h0000 : mem_m[i][a];
               q_push(i, {32'(t + lat - 1), err, w});
               for (int e = t; e < t + lat; e++) exp_busy[i][e] = 1'b1;
               free_edge[i] = t + lat + 1;
            end else begin
               exp_drop[i][t] = 1'b1;
            end
         end
         // Fetch above sees old contents; the load lands afterwards.
         if (ld && int'(la) < dep) mem_m[i][la] = ld_d;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive_cycle(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < NI; i++) begin
         chk({tag, "_ins"}, i, 32'(ins_w[i]), 32'h0);
         chk({tag, "_en_out"}, i, 32'(en_out_w[i]), 32'h0);
         chk({tag, "_busy"}, i, 32'(busy_w[i]), 32'h0);
         chk({tag, "_req_drop"}, i, 32'(drop_w[i]), 32'h0);
         chk({tag, "_addr_err"}, i, 32'(err_w[i]), 32'h0);
      end
   endtask

   task automatic do_reset(input int hold);
      #2;
      rst_n = 1'b0; en_in = 1'b0; load_en = 1'b0;
      #1;
      check_all_zero("mid_reset");
      for (int i = 0; i < NI; i++) begin
         q_flush(i);
         free_edge[i] = 0;
         last_ins[i] = 16'h0000;
         for (int e = edge_cnt + 1; e < edge_cnt + hold + 8; e++) begin
            exp_busy[i][e] = 1'b0;
            exp_drop[i][e] = 1'b0;
         end
      end
      repeat (hold) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NI; i++) begin
            int e;
            logic [48:0] v;
            e = edge_cnt;
            chk("busy", i, 32'(busy_w[i]), 32'(exp_busy[i][e]));
            chk("req_drop", i, 32'(drop_w[i]), 32'(exp_drop[i][e]));
            if (en_out_w[i]) begin
               if (q_size(i) == 0) begin
                  compares++; fails++;
                  $display("FAIL en_out_unexpected u%0d edge %0d: got 1 expected 0", i, e);
               end else begin
                  v = q_pop(i);
                  chk("resp_edge", i, 32'(e), v[48:17]);
                  chk("ins", i, 32'(ins_w[i]), 32'(v[15:0]));
                  chk("addr_err", i, 32'(err_w[i]), 32'(v[16]));
                  last_ins[i] = v[15:0];
               end
            end else begin
               chk("ins_hold", i, 32'(ins_w[i]), 32'(last_ins[i]));
               if (q_size(i) > 0 && q_front_edge(i) <= e) begin
                  compares++; fails++;
                  $display("FAIL en_out_missing u%0d edge %0d: got 0 expected 1 at edge %0d",
                           i, e, q_front_edge(i));
                  v = q_pop(i);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < NI; i++) begin
         free_edge[i] = 0;
         last_ins[i] = 16'h0000;
      end
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // Program every word so no fetch ever reads uninitialised storage.
      for (int a = 0; a < 256; a++) drive_cycle(1'b0, 8'h00, 1'b1, 8'(a), 16'($urandom));

      // Basic fetch of a freshly loaded word.
      drive_cycle(1'b0, 8'h00, 1'b1, 8'h05, 16'hA3C7);
      drive_cycle(1'b1, 8'h05, 1'b0, 8'h00, 16'h0000);
      idle(5);

      // Back-to-back fetches two cycles apart.
      drive_cycle(1'b0, 8'h00, 1'b1, 8'h00, 16'h1000);
      drive_cycle(1'b0, 8'h00, 1'b1, 8'h01, 16'h2001);
      drive_cycle(1'b0, 8'h00, 1'b1, 8'h02, 16'h3002);
      drive_cycle(1'b1, 8'h00, 1'b0, 8'h00, 16'h0000);
      idle(1);
      drive_cycle(1'b1, 8'h01, 1'b0, 8'h00, 16'h0000);
      idle(1);
      drive_cycle(1'b1, 8'h02, 1'b0, 8'h00, 16'h0000);
      idle(5);

      // Request while busy is dropped.
      drive_cycle(1'b0, 8'h00, 1'b1, 8'h10, 16'h0F0F);
      drive_cycle(1'b1, 8'h10, 1'b0, 8'h00, 16'h0000);
      drive_cycle(1'b1, 8'h11, 1'b0, 8'h00, 16'h0000);
      idle(5);

      // Same-edge fetch and load of one address: read-before-write.
      drive_cycle(1'b0, 8'h00, 1'b1, 8'h20, 16'h1111);
      drive_cycle(1'b1, 8'h20, 1'b1, 8'h20, 16'h2222);
      idle(5);
      drive_cycle(1'b1, 8'h20, 1'b0, 8'h00, 16'h0000);
      idle(5);

      // Out-of-range fetch on the shallow instance, then a clean one.
      drive_cycle(1'b1, 8'h90, 1'b0, 8'h00, 16'h0000);
      idle(5);
      drive_cycle(1'b1, 8'h05, 1'b0, 8'h00, 16'h0000);
      idle(5);

      // Load during an in-flight fetch of the same address.
      drive_cycle(1'b1, 8'h21, 1'b0, 8'h00, 16'h0000);
      drive_cycle(1'b0, 8'h00, 1'b1, 8'h21, 16'h5A5A);
      idle(5);

      // Reset in the middle of a fetch; memory survives.
      drive_cycle(1'b0, 8'h00, 1'b1, 8'h33, 16'hBEEF);
      drive_cycle(1'b1, 8'h33, 1'b0, 8'h00, 16'h0000);
      do_reset(3);
      idle(6);
      drive_cycle(1'b1, 8'h33, 1'b0, 8'h00, 16'h0000);
      idle(5);

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         logic        en;
         logic [7:0]  a;
         logic        ld;
         logic [7:0]  la;
         en = ($urandom_range(0, 2) == 0);
         a  = 8'($urandom_range(0, 255));
         ld = ($urandom_range(0, 3) == 0);
         la = ($urandom_range(0, 3) == 0) ? a : 8'($urandom_range(0, 255));
         drive_cycle(en, a, ld, la, 16'($urandom));
      end

      idle(10);
      for (int i = 0; i < NI; i++) chk("queue_empty", i, 32'(q_size(i)), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
